// File: rtl/bumpy_tile_responder.sv
// Bumpy tile responder: reacts to tile landings with coin pickup, teleport, death/win and map rewrites.
// Optional breakable-tile behaviour is built only when TILE_RESP_BRAK_EN is defined.
module bumpy_tile_responder #(
    parameter int NUM_OF_ROWS = 7,
    parameter int NUM_OF_COLS = 10,
    parameter int TP_FRAMES   = 16,
    parameter int BRAK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        landed,
    input  logic [2:0]  tile_type,
    input  logic [3:0]  tile_col,
    input  logic [2:0]  tile_row,
    input  logic [7:0]  teleport_cordinates,
    input  logic        wr_ack,
    output logic        wr_en,
    output logic [3:0]  wr_col,
    output logic [2:0]  wr_row,
    output logic [2:0]  wr_type,
    output logic        tp_valid,
    output logic [10:0] tp_x,
    output logic [10:0] tp_y,
    output logic [7:0]  coins,
    output logic        die,
    output logic        win,
    output logic        busy
);

    typedef enum logic [2:0] {
        T_FREE = 3'd0,
        T_REGU = 3'd1,
        T_GATE = 3'd2,
        T_COIN = 3'd3,
        T_PORT = 3'd4,
        T_SPIK = 3'd5,
        T_BRAK = 3'd6,
        T_RSVD = 3'd7
    } tile_e;

`ifdef TILE_RESP_BRAK_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TP_WAIT   = 3'd1,
        WRITE     = 3'd2,
        HALT      = 3'd3,
        BRAK_WAIT = 3'd4
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TP_WAIT = 2'd1,
        WRITE   = 2'd2,
        HALT    = 2'd3
    } state_e;
`endif

    // One shared frame counter, wide enough for the longer of the two waits.
    localparam int CNT_MAX = (TP_FRAMES > BRAK_FRAMES) ? TP_FRAMES : BRAK_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TP_LAST = CNT_W'(TP_FRAMES);
`ifdef TILE_RESP_BRAK_EN
    localparam logic [CNT_W-1:0] BRAK_LAST = CNT_W'(BRAK_FRAMES);
`endif

    state_e           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
    logic [3:0]       dest_col, dest_col_d;
    logic [3:0]       dest_row, dest_row_d;
    logic [7:0]       coins_d;
    logic [3:0]       wr_col_d;
    logic [2:0]       wr_row_d;
    logic [2:0]       wr_type_d;
    logic [10:0]      tp_x_d, tp_y_d;
    logic             tp_valid_d, die_d, win_d;
    logic             dest_ok;

    assign cnt_inc = cnt + 1'b1;
    assign dest_ok = (int'(teleport_cordinates[7:4]) < NUM_OF_COLS) &&
                     (int'(teleport_cordinates[3:0]) < NUM_OF_ROWS);

    // wr_en follows the state directly, so it rises on the very cycle WRITE is entered.
    assign wr_en = (state == WRITE);
    assign busy  = (state != IDLE);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d    = state;
        cnt_d      = cnt;
        dest_col_d = dest_col;
        dest_row_d = dest_row;
        coins_d    = coins;
        wr_col_d   = wr_col;
        wr_row_d   = wr_row;
        wr_type_d  = wr_type;
        tp_x_d     = tp_x;
        tp_y_d     = tp_y;
        tp_valid_d = 1'b0;
        die_d      = 1'b0;
        win_d      = 1'b0;

        case (state)
            IDLE: begin
                if (landed) begin
                    case (tile_e'(tile_type))
                        T_COIN: begin
                            coins_d   = (coins == 8'hFF) ? coins : coins + 8'd1;
                            wr_col_d  = tile_col;
                            wr_row_d  = tile_row;
                            wr_type_d = T_FREE;
                            state_d   = WRITE;
                        end
                        T_PORT: begin
                            if (dest_ok) begin
                                dest_col_d = teleport_cordinates[7:4];
                                dest_row_d = teleport_cordinates[3:0];
                                cnt_d      = '0;
                                state_d    = TP_WAIT;
                            end
                        end
                        T_SPIK: begin
                            die_d   = 1'b1;
                            state_d = HALT;
                        end
                        T_GATE: begin
                            win_d   = 1'b1;
                            state_d = HALT;
                        end
`ifdef TILE_RESP_BRAK_EN
                        T_BRAK: begin
                            wr_col_d = tile_col;
                            wr_row_d = tile_row;
                            cnt_d    = '0;
                            state_d  = BRAK_WAIT;
                        end
`endif
                        default: ;
                    endcase
                end
            end

            TP_WAIT: begin
                if (startOfFrame) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TP_LAST) begin
                        tp_valid_d = 1'b1;
                        tp_x_d     = {1'b0, dest_col, 6'b0};
                        tp_y_d     = {1'b0, dest_row, 6'b0};
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end
                end
            end

            WRITE: begin
                if (wr_ack) state_d = IDLE;
            end

`ifdef TILE_RESP_BRAK_EN
            BRAK_WAIT: begin
                if (startOfFrame) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == BRAK_LAST) begin
                        wr_type_d = T_FREE;
                        cnt_d     = '0;
                        state_d   = WRITE;
                    end
                end
            end
`endif

            HALT: ;

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            dest_col <= '0;
            dest_row <= '0;
            coins    <= '0;
            wr_col   <= '0;
            wr_row   <= '0;
            wr_type  <= '0;
            tp_x     <= '0;
            tp_y     <= '0;
            tp_valid <= 1'b0;
            die      <= 1'b0;
            win      <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            dest_col <= dest_col_d;
            dest_row <= dest_row_d;
            coins    <= coins_d;
            wr_col   <= wr_col_d;
            wr_row   <= wr_row_d;
            wr_type  <= wr_type_d;
            tp_x     <= tp_x_d;
            tp_y     <= tp_y_d;
            tp_valid <= tp_valid_d;
            die      <= die_d;
            win      <= win_d;
        end
    end

endmodule

// File: doc/bumpy_tile_responder.md
BUMPY_TILE_RESPONDER -- requirements
Module: bumpy_tile_responder

Interface
REQ-001 Parameter NUM_OF_ROWS, default 7: map rows.
REQ-002 Parameter NUM_OF_COLS, default 10: map columns.
REQ-003 Parameter TP_FRAMES, default 16: frames between PORT landing and teleport.
REQ-004 Parameter BRAK_FRAMES, default 30: frames between BRAK landing and tile removal.
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 startOfFrame  in  1  one-cycle pulse per video frame.
REQ-008 landed  in  1  one-cycle pulse: Bumpy settled on a tile.
REQ-009 tile_type  in  3  type of the landed tile: FREE=0, REGU=1, GATE=2, COIN=3, PORT=4, SPIK=5, BRAK=6, 7 reserved.
REQ-010 tile_col  in  4  column index of the landed tile.
REQ-011 tile_row  in  3  row index of the landed tile.
REQ-012 teleport_cordinates  in  8  [7:4] = destination column, [3:0] = destination row.
REQ-013 wr_ack  in  1  map write accepted this cycle.
REQ-014 wr_en  out  1  map write request; held until acknowledged.
REQ-015 wr_col, wr_row, wr_type  out  4/3/3  map write address and new tile type.
REQ-016 tp_valid  out  1  one-cycle teleport command.
REQ-017 tp_x, tp_y  out  11/11  teleport destination top-left pixel, index shifted left by 6.
REQ-018 coins  out  8  collected-coin count.
REQ-019 die, win  out  1/1  one-cycle event pulses.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 FSM states: IDLE, TP_WAIT, WRITE, BRAK_WAIT, HALT.
REQ-022 landed, tile_type, tile_col, tile_row and teleport_cordinates are sampled only in IDLE when landed=1.
- landed in any other state: ignored, no queueing.
REQ-023 IDLE actions by sampled type:
- FREE, REGU, reserved: no action.
- COIN: coins += 1, saturating at 255; latch address; wr_type=FREE; go to WRITE.
- PORT: latch destination; go to TP_WAIT with frame counter = 0.
- SPIK: pulse die the next cycle; go to HALT.
- GATE: pulse win the next cycle; go to HALT.
- BRAK: latch address; go to BRAK_WAIT with frame counter = 0.
REQ-024 PORT destination bounds:
- Column >= NUM_OF_COLS or row >= NUM_OF_ROWS: remain in IDLE; no teleport is issued.
REQ-025 TP_WAIT:
- Counter increments on each startOfFrame.
- When the counter reaches TP_FRAMES: tp_valid=1 for exactly one cycle, with tp_x = col<<6 and tp_y = row<<6; return to IDLE.
- tp_x and tp_y hold their value after tp_valid falls.
REQ-026 BRAK_WAIT:
- Counter increments on each startOfFrame.
- When the counter reaches BRAK_FRAMES: wr_type=FREE; go to WRITE.
REQ-027 WRITE handshake:
- wr_en is asserted on the cycle WRITE is entered.
- wr_col, wr_row and wr_type stay stable while wr_en=1.
- On the cycle wr_ack=1 with wr_en=1: deassert wr_en the next cycle and return to IDLE.
- wr_ack while wr_en=0: ignored.
- If wr_ack is already high when WRITE is entered, the write completes in one cycle.
REQ-028 HALT: all inputs are ignored until reset.
REQ-029 startOfFrame and landed arriving in the same cycle in IDLE: landed is processed; that frame pulse is not counted.

Reset
REQ-030 While reset=1, on the next clk edge:
- State goes to IDLE; counters go to 0.
- wr_en, tp_valid, die, win and busy go to 0.
- coins, tp_x, tp_y, wr_col, wr_row and wr_type go to 0.
REQ-031 Reset asserted mid-WRITE or mid-wait:
- The pending write or teleport is abandoned.
- No pulse is emitted afterwards.

Configuration
REQ-032 Macro TILE_RESP_BRAK_EN:
- Defined: BRAK behaves per REQ-023 and REQ-026.
- Undefined: BRAK is treated as REGU (no action), and the BRAK_WAIT state and its counter are not built.

Verification
REQ-033 Reset, then landed with tile_type=COIN, col=3, row=2, and wr_ack tied to 1:
- coins=1.
- wr_en is high for 1 cycle with wr_col=3, wr_row=2, wr_type=FREE.
- FSM returns to IDLE.
REQ-034 landed with PORT and teleport_cordinates=8'h76, then 16 startOfFrame pulses:
- A single tp_valid pulse with tp_x=448, tp_y=384.
- landed pulses sent during the wait are ignored.
REQ-035 landed with PORT and teleport_cordinates=8'hA0: no tp_valid, busy stays 0.
REQ-036 256 COIN landings with wr_ack=1:
- coins saturates at 255.
- The third landing holds wr_ack low for 5 cycles: wr_en stays high with stable address throughout.
REQ-037 landed with BRAK, col=7, row=3 (macro defined):
- Write to (7,3) with FREE occurs only after the 30th startOfFrame.
- With the macro undefined: no write occurs.
REQ-038 landed with SPIK: a die pulse, then COIN and GATE landings are ignored; reset returns all outputs to 0.
